islip_scheduler: RTL and testbench
==================================

# islip_scheduler

Single-iteration iSLIP crossbar scheduler for the 4x4 switch. It samples the VOQ empty flags of all four ingress blocks and computes a conflict-free ingress-to-egress match once per slot. It then pulses each matched ingress's dequeue/send strobe with the chosen VOQ and holds the crossbar configuration for the whole slot. It sits between the ingress blocks' VOQ status and sched_sel/sched_done inputs and the crossbar's select lines.

## Interface
- NUM_PORTS, 4, ingress and egress port count (fixed at 4 for this revision; port index 2 bits)
- SLOT_CYCLES, 10, cycles from one ISSUE to the next MATCH; covers one block transfer (1 meta + 1 address + 8 data cycles); minimum 2

- clk  in  1  clock
- reset  in  1  reset reset, synchronous, active-high; clock clk
- enable  in  1  scheduling enable, sampled in IDLE and at slot end
- voq_empty  in  16  bit i*4+e = ingress i's VOQ for egress e is empty
- sched_en  out  4  bit i: one-cycle strobe to ingress i's sched_done
- sched_sel  out  8  bits 2i+1:2i: VOQ (egress) ingress i dequeues; valid when sched_en[i]
- xbar_src  out  8  bits 2e+1:2e: ingress driving egress e
- xbar_valid  out  4  bit e: egress e connected this slot
- busy  out  1  state != IDLE

## Operation
- States: IDLE, MATCH, ISSUE, HOLD.
- IDLE: enable=1 -> MATCH.
- MATCH: request req[i][e] = ~voq_empty[i*4+e], sampled this cycle.
  - Grant: each egress e grants the first requesting ingress at or after grant pointer g[e], circular.
  - Accept: each ingress i accepts the first granting egress at or after accept pointer a[i], circular.
  - Accepted pairs are registered.
  - Non-empty match -> ISSUE. Empty match -> MATCH if enable, else IDLE; no strobes and no pointer change.
- ISSUE: sched_en[i]=1 and sched_sel[i]=e for each accepted (i,e).
  - xbar_src[e]=i and xbar_valid[e]=1 for matched egresses; others have xbar_valid=0 and xbar_src=0.
  - Pointer update, accepted pairs only: g[e] <= (i+1) mod 4, a[i] <= (e+1) mod 4. Unmatched pointers hold.
  - Next state: HOLD.
- HOLD: slot counter runs SLOT_CYCLES-1 cycles; xbar_src/xbar_valid held constant.
  - On the last cycle: enable ? MATCH : IDLE.
  - Disabling enable mid-slot never truncates the slot.
- voq_empty is ignored outside MATCH. This covers the VOQ status lag after dequeue.
- Pointer arithmetic: 2-bit modulo-4 wrap.
- Slot counter: $clog2(SLOT_CYCLES) bits, cleared on entering HOLD.

## Timing
- Reset values: state IDLE, all g[e]=0 and a[i]=0, sched_en=0, sched_sel=0, xbar_src=0, xbar_valid=0, busy=0, slot counter 0.
- Reset mid-slot has the same effect: outputs clear the following cycle.
- Latency:
  - enable high in IDLE at cycle t -> MATCH at t+1 -> strobes and crossbar update at t+2 (ISSUE).
  - Next MATCH at t+2+SLOT_CYCLES.
- sched_en is high exactly one cycle per slot and is registered (no combinational path from voq_empty).
- xbar_* update in the same cycle as sched_en and hold until the next ISSUE.
- xbar_valid drops to 0 on the cycle after the last HOLD cycle (return to MATCH or IDLE).
- Each ingress has at most one strobe per slot. Each egress has at most one source.

## Structure
- switch_pkg holds: NUM_PORTS, port_t (logic [1:0]), sched_state_t enum, and the SLOT_CYCLES default.
- Sub-module rr_arbiter: 4-way circular priority picker.
  - Inputs: req[3:0], ptr.
  - Outputs: gnt one-hot, gnt_idx, any.
  - Eight instances: four grant arbiters, four accept arbiters.
- The scheduler owns the FSM, pointers, slot counter, and output registers.

## Test plan
- Single request from reset: only voq_empty bit 9 low (i2 to e1) -> ISSUE has sched_en=0100, sched_sel[2]=1, xbar_valid=0010, xbar_src[1]=2; afterwards g[1]=3, a[2]=2.
- All 16 VOQs non-empty from reset:
  - slot 1: sched_en=0001, sched_sel[0]=0.
  - slot 2: matches (i0,e1) and (i1,e0).
  - Pointers desynchronise until a full 4-match, checked against a reference model every slot.
- Conflict: i0 and i3 request only e2, continuously -> slot 1 grants i0, slot 2 grants i3, slot 3 grants i0.
- Empty match: all voq_empty=1 with enable=1 -> state stays MATCH, sched_en=0 and xbar_valid=0 for 50 cycles, pointers unchanged.
- Enable drop mid-HOLD: slot still completes SLOT_CYCLES; then IDLE, busy=0, no further strobes.
- Reset asserted in HOLD cycle 4 -> next cycle all outputs 0, state IDLE; a repeat of the single-request test gives the identical result.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and constants for the 4x4 switch scheduler.
package switch_pkg;

  localparam int unsigned NUM_PORTS           = 4;
  localparam int unsigned SLOT_CYCLES_DEFAULT = 10;

  typedef logic [1:0] port_t;

  typedef enum logic [1:0] {
    StIdle,
    StMatch,
    StIssue,
    StHold
  } sched_state_t;

endpackage

// File: rtl/islip_scheduler_if.sv
// Scheduler status/command bundle between ingress blocks, crossbar and scheduler.
interface islip_scheduler_if;
  import switch_pkg::*;

  logic                             enable;
  logic [NUM_PORTS*NUM_PORTS-1:0]   voq_empty;
  logic [NUM_PORTS-1:0]             sched_en;
  logic [2*NUM_PORTS-1:0]           sched_sel;
  logic [2*NUM_PORTS-1:0]           xbar_src;
  logic [NUM_PORTS-1:0]             xbar_valid;
  logic                             busy;

  modport master (
    output enable, voq_empty,
    input  sched_en, sched_sel, xbar_src, xbar_valid, busy
  );

  modport slave (
    input  enable, voq_empty,
    output sched_en, sched_sel, xbar_src, xbar_valid, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// 4-way circular priority picker: first request at or after i_ptr wins.
module rr_arbiter
  import switch_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  port_t                i_ptr,
  output logic [NUM_PORTS-1:0] o_gnt,
  output port_t                o_gnt_idx,
  output logic                 o_any
);

  port_t w_idx;

  // Scan from furthest to nearest so the nearest requester is written last.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_idx     = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_idx = i_ptr + port_t'(k);
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/islip_scheduler.sv
// Single-iteration iSLIP scheduler: one conflict-free match per slot, crossbar
// configuration held for the whole slot.
module islip_scheduler
  import switch_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = SLOT_CYCLES_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  islip_scheduler_if.slave sif
);

  localparam int unsigned     CntW    = $clog2(SLOT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(SLOT_CYCLES - 2);

  sched_state_t           r_state;
  port_t                  r_gptr [NUM_PORTS];
  port_t                  r_aptr [NUM_PORTS];
  logic [CntW-1:0]        r_slot_cnt;
  logic [NUM_PORTS-1:0]   r_sched_en;
  logic [2*NUM_PORTS-1:0] r_sched_sel;
  logic [2*NUM_PORTS-1:0] r_xbar_src;
  logic [NUM_PORTS-1:0]   r_xbar_valid;

  // w_greq[e][i]: ingress i requests egress e; w_areq[i][e]: egress e grants ingress i.
  logic [NUM_PORTS-1:0]   w_greq [NUM_PORTS];
  logic [NUM_PORTS-1:0]   w_gnt [NUM_PORTS];
  port_t                  w_gnt_idx [NUM_PORTS];
  logic                   w_gnt_any [NUM_PORTS];
  logic [NUM_PORTS-1:0]   w_areq [NUM_PORTS];
  logic [NUM_PORTS-1:0]   w_acc [NUM_PORTS];
  port_t                  w_acc_idx [NUM_PORTS];
  logic                   w_acc_any [NUM_PORTS];

  logic [NUM_PORTS-1:0]   w_sched_en;
  logic [2*NUM_PORTS-1:0] w_sched_sel;
  logic [2*NUM_PORTS-1:0] w_xbar_src;
  logic [NUM_PORTS-1:0]   w_xbar_valid;

  always_comb begin
    for (int e = 0; e < NUM_PORTS; e++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_greq[e][i] = ~sif.voq_empty[i*NUM_PORTS + e];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int e = 0; e < NUM_PORTS; e++) begin
        w_areq[i][e] = w_gnt[e][i];
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : gen_arb
    rr_arbiter u_grant (
      .i_req     (w_greq[p]),
      .i_ptr     (r_gptr[p]),
      .o_gnt     (w_gnt[p]),
      .o_gnt_idx (w_gnt_idx[p]),
      .o_any     (w_gnt_any[p])
    );

    rr_arbiter u_accept (
      .i_req     (w_areq[p]),
      .i_ptr     (r_aptr[p]),
      .o_gnt     (w_acc[p]),
      .o_gnt_idx (w_acc_idx[p]),
      .o_any     (w_acc_any[p])
    );
  end

  always_comb begin
    w_sched_en   = '0;
    w_sched_sel  = '0;
    w_xbar_src   = '0;
    w_xbar_valid = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_sched_en[p]        = w_acc_any[p];
      w_sched_sel[2*p +: 2] = w_acc_any[p] ? w_acc_idx[p] : 2'd0;
      // Egress p is connected only if its granted ingress accepted it back.
      w_xbar_valid[p]      = w_gnt_any[p] & w_acc[w_gnt_idx[p]][p];
      w_xbar_src[2*p +: 2] = w_xbar_valid[p] ? w_gnt_idx[p] : 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_slot_cnt   <= '0;
      r_sched_en   <= '0;
      r_sched_sel  <= '0;
      r_xbar_src   <= '0;
      r_xbar_valid <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_gptr[p] <= '0;
        r_aptr[p] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (sif.enable) r_state <= StMatch;
        end
        StMatch: begin
          r_sched_en   <= w_sched_en;
          r_sched_sel  <= w_sched_sel;
          r_xbar_src   <= w_xbar_src;
          r_xbar_valid <= w_xbar_valid;
          if (|w_sched_en) r_state <= StIssue;
          else if (!sif.enable) r_state <= StIdle;
        end
        StIssue: begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_xbar_valid[p]) r_gptr[p] <= r_xbar_src[2*p +: 2] + 2'd1;
            if (r_sched_en[p]) r_aptr[p] <= r_sched_sel[2*p +: 2] + 2'd1;
          end
          r_sched_en  <= '0;
          r_sched_sel <= '0;
          r_slot_cnt  <= '0;
          r_state     <= StHold;
        end
        StHold: begin
          if (r_slot_cnt == LastCnt) begin
            r_xbar_src   <= '0;
            r_xbar_valid <= '0;
            r_state      <= sif.enable ? StMatch : StIdle;
          end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign sif.sched_en   = r_sched_en;
  assign sif.sched_sel  = r_sched_sel;
  assign sif.xbar_src   = r_xbar_src;
  assign sif.xbar_valid = r_xbar_valid;
  assign sif.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_islip_scheduler.sv
// Directed bench for islip_scheduler: hand-computed vectors plus a small iSLIP model.
module tb_islip_scheduler;
  import switch_pkg::*;

  localparam int unsigned SLOT = 10;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  islip_scheduler_if sif ();

  islip_scheduler #(
    .SLOT_CYCLES (SLOT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  int checks = 0;
  int errors = 0;
  int mg[4];
  int ma[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sif.enable = 1'b0;
    sif.voq_empty = '1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mg[k] = 0;
      ma[k] = 0;
    end
  endtask

  // Reference iSLIP iteration; updates the model pointers for matched pairs.
  task automatic model_slot(input logic [15:0] empty, output logic [3:0] en,
                            output logic [7:0] sel, output logic [3:0] xv,
                            output logic [7:0] xs);
    int  gsrc[4];
    bit  gv[4];
    bit  done;
    int  c;
    en = '0; sel = '0; xv = '0; xs = '0;
    for (int e = 0; e < 4; e++) begin
      gv[e] = 0;
      gsrc[e] = 0;
      for (int k = 0; k < 4; k++) begin
        c = (mg[e] + k) % 4;
        if (!gv[e] && !empty[c*4 + e]) begin
          gv[e] = 1;
          gsrc[e] = c;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      done = 0;
      for (int k = 0; k < 4; k++) begin
        c = (ma[i] + k) % 4;
        if (!done && gv[c] && gsrc[c] == i) begin
          done = 1;
          en[i] = 1'b1;
          sel[2*i +: 2] = c[1:0];
          xv[c] = 1'b1;
          xs[2*c +: 2] = i[1:0];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        c = int'(sel[2*i +: 2]);
        mg[c] = (i + 1) % 4;
        ma[i] = (c + 1) % 4;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({sif.busy, sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b sel=%h xv=%b xs=%h busy=%b, want all 0",
               sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src, sif.busy);
    end
    checks++;
    if ({dut.r_gptr[0], dut.r_gptr[1], dut.r_gptr[2], dut.r_gptr[3], dut.r_aptr[0],
         dut.r_aptr[1], dut.r_aptr[2], dut.r_aptr[3]} !== 16'd0) begin
      errors++;
      $display("FAIL reset_pointers: got g=%0d%0d%0d%0d a=%0d%0d%0d%0d, want all 0",
               dut.r_gptr[0], dut.r_gptr[1], dut.r_gptr[2], dut.r_gptr[3],
               dut.r_aptr[0], dut.r_aptr[1], dut.r_aptr[2], dut.r_aptr[3]);
    end
  endtask

  // Expects the DUT in IDLE with reset released.
  task automatic test_single(input string tag);
    sif.enable = 1'b1;
    sif.voq_empty = ~16'h0200;
    tick();
    checks++;
    if ({sif.busy, sif.sched_en} !== 5'b1_0000) begin
      errors++;
      $display("FAIL %s_match: got busy=%b en=%b, want busy=1 en=0000", tag, sif.busy,
               sif.sched_en);
    end
    tick();
    checks++;
    if ({sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src} !==
        {4'b0100, 8'h10, 4'b0010, 8'h08}) begin
      errors++;
      $display("FAIL %s_issue: got en=%b sel=%h xv=%b xs=%h, want en=0100 sel=10 xv=0010 xs=08",
               tag, sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src);
    end
    tick();
    checks++;
    if ({dut.r_gptr[0], dut.r_gptr[1], dut.r_gptr[2], dut.r_gptr[3], dut.r_aptr[0],
         dut.r_aptr[1], dut.r_aptr[2], dut.r_aptr[3]} !== {8'b00_11_00_00, 8'b00_00_10_00}) begin
      errors++;
      $display("FAIL %s_pointers: got g=%0d%0d%0d%0d a=%0d%0d%0d%0d, want g=0300 a=0020", tag,
               dut.r_gptr[0], dut.r_gptr[1], dut.r_gptr[2], dut.r_gptr[3],
               dut.r_aptr[0], dut.r_aptr[1], dut.r_aptr[2], dut.r_aptr[3]);
    end
    sif.enable = 1'b0;
    for (int n = 0; n < 8; n++) tick();
    checks++;
    if ({sif.busy, sif.sched_en, sif.xbar_valid, sif.xbar_src} !== {1'b1, 4'b0, 4'b0010, 8'h08})
    begin
      errors++;
      $display("FAIL %s_last_hold: got busy=%b en=%b xv=%b xs=%h, want busy=1 en=0 xv=0010 xs=08",
               tag, sif.busy, sif.sched_en, sif.xbar_valid, sif.xbar_src);
    end
    tick();
    checks++;
    if ({sif.busy, sif.xbar_valid, sif.xbar_src} !== 13'd0) begin
      errors++;
      $display("FAIL %s_idle: got busy=%b xv=%b xs=%h, want all 0", tag, sif.busy,
               sif.xbar_valid, sif.xbar_src);
    end
  endtask

  task automatic test_all_requests();
    logic [3:0] en, xv;
    logic [7:0] sel, xs;
    apply_reset();
    sif.enable = 1'b1;
    sif.voq_empty = '0;
    tick();
    tick();
    for (int s = 0; s < 6; s++) begin
      model_slot(16'h0000, en, sel, xv, xs);
      checks++;
      if ({sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src} !== {en, sel, xv, xs}) begin
        errors++;
        $display("FAIL all_slot%0d: got en=%b sel=%h xv=%b xs=%h, want en=%b sel=%h xv=%b xs=%h",
                 s, sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src, en, sel, xv, xs);
      end
      if (s == 0) begin
        checks++;
        if ({sif.sched_en, sif.sched_sel} !== {4'b0001, 8'h00}) begin
          errors++;
          $display("FAIL all_first: got en=%b sel=%h, want en=0001 sel=00", sif.sched_en,
                   sif.sched_sel);
        end
      end
      if (s == 1) begin
        checks++;
        if ({sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src} !==
            {4'b0011, 8'h01, 4'b0011, 8'h01}) begin
          errors++;
          $display("FAIL all_second: got en=%b sel=%h xv=%b xs=%h, want 0011 01 0011 01",
                   sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src);
        end
      end
      if (s == 3) begin
        checks++;
        if (sif.sched_en !== 4'b1111) begin
          errors++;
          $display("FAIL all_full_match: got en=%b, want 1111", sif.sched_en);
        end
      end
      for (int n = 0; n < 5; n++) tick();
      checks++;
      if ({sif.sched_en, sif.xbar_valid, sif.xbar_src} !== {4'b0, xv, xs}) begin
        errors++;
        $display("FAIL all_hold%0d: got en=%b xv=%b xs=%h, want en=0000 xv=%b xs=%h", s,
                 sif.sched_en, sif.xbar_valid, sif.xbar_src, xv, xs);
      end
      for (int n = 0; n < int'(SLOT) - 4; n++) tick();
    end
  endtask

  task automatic test_conflict();
    logic [3:0] exp_en;
    logic [7:0] exp_sel, exp_xs;
    apply_reset();
    sif.enable = 1'b1;
    sif.voq_empty = 16'hBFFB;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      exp_en  = (s == 1) ? 4'b1000 : 4'b0001;
      exp_sel = (s == 1) ? 8'h80 : 8'h02;
      exp_xs  = (s == 1) ? 8'h30 : 8'h00;
      checks++;
      if ({sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src} !==
          {exp_en, exp_sel, 4'b0100, exp_xs}) begin
        errors++;
        $display("FAIL conflict_slot%0d: got en=%b sel=%h xv=%b xs=%h, want en=%b sel=%h xv=0100 xs=%h",
                 s, sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src, exp_en,
                 exp_sel, exp_xs);
      end
      for (int n = 0; n < int'(SLOT) + 1; n++) tick();
    end
  endtask

  task automatic test_empty_match();
    int bad = 0;
    apply_reset();
    sif.enable = 1'b1;
    sif.voq_empty = '1;
    tick();
    for (int n = 0; n < 50; n++) begin
      checks++;
      if ({dut.r_state, sif.busy, sif.sched_en, sif.xbar_valid} !== {StMatch, 1'b1, 8'd0}) begin
        errors++;
        bad++;
        if (bad < 4)
          $display("FAIL empty_cycle%0d: got state=%0d busy=%b en=%b xv=%b, want MATCH 1 0 0",
                   n, dut.r_state, sif.busy, sif.sched_en, sif.xbar_valid);
      end
      tick();
    end
    checks++;
    if ({dut.r_gptr[0], dut.r_gptr[1], dut.r_gptr[2], dut.r_gptr[3], dut.r_aptr[0],
         dut.r_aptr[1], dut.r_aptr[2], dut.r_aptr[3]} !== 16'd0) begin
      errors++;
      $display("FAIL empty_pointers: got nonzero pointers, want all 0");
    end
    sif.enable = 1'b0;
    tick();
    checks++;
    if (sif.busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_to_idle: got busy=%b, want 0", sif.busy);
    end
  endtask

  task automatic test_enable_drop();
    int hold = 1;
    int xv_bad = 0;
    int strobes = 0;
    apply_reset();
    sif.enable = 1'b1;
    sif.voq_empty = ~16'h0080;
    tick();
    tick();
    checks++;
    if ({sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src} !==
        {4'b0010, 8'h0C, 4'b1000, 8'h40}) begin
      errors++;
      $display("FAIL drop_issue: got en=%b sel=%h xv=%b xs=%h, want 0010 0c 1000 40",
               sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src);
    end
    tick();
    sif.enable = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (!sif.busy) break;
      hold++;
      if (sif.xbar_valid !== 4'b1000) xv_bad++;
    end
    checks++;
    if (hold != int'(SLOT) - 1) begin
      errors++;
      $display("FAIL drop_hold_len: got %0d hold cycles, want %0d", hold, SLOT - 1);
    end
    checks++;
    if (xv_bad != 0) begin
      errors++;
      $display("FAIL drop_xbar_held: got %0d cycles with wrong xbar_valid, want 0", xv_bad);
    end
    for (int n = 0; n < 20; n++) begin
      if (sif.sched_en !== 4'b0 || sif.busy !== 1'b0 || sif.xbar_valid !== 4'b0) strobes++;
      tick();
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL drop_idle_quiet: got %0d active cycles after slot, want 0", strobes);
    end
  endtask

  task automatic test_reset_mid_slot();
    apply_reset();
    sif.enable = 1'b1;
    sif.voq_empty = ~16'h0200;
    tick();
    tick();
    for (int n = 0; n < 4; n++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({dut.r_state, sif.busy, sif.sched_en, sif.sched_sel, sif.xbar_valid, sif.xbar_src,
         dut.r_gptr[1], dut.r_aptr[2]} !== 31'd0) begin
      errors++;
      $display("FAIL midreset_clear: got state=%0d busy=%b xv=%b xs=%h g1=%0d a2=%0d, want all 0",
               dut.r_state, sif.busy, sif.xbar_valid, sif.xbar_src, dut.r_gptr[1],
               dut.r_aptr[2]);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mg[k] = 0;
      ma[k] = 0;
    end
    test_single("rerun");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sif.enable = 1'b0;
    sif.voq_empty = '1;
    test_reset();
    test_single("single");
    test_all_requests();
    test_conflict();
    test_empty_match();
    test_enable_drop();
    test_reset_mid_slot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
